// File: rtl/fifo_vcfc_pkg.sv
// fifo_vcfc_pkg: shared constants and types for the VC flow-control FIFO.
//   DATA_W_DEF / DEPTH_DEF : default word width and entry count
//   AF_RST / AE_RST        : threshold values loaded while reset is high
//   AF_* / AE_*            : nibble positions inside umbrales_VCFC
//   thr_t / thr_unpack     : registered threshold pair and its decoder
package fifo_vcfc_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int DEPTH_DEF  = 8;

  localparam logic [3:0] AF_RST = 4'd6;
  localparam logic [3:0] AE_RST = 4'd1;

  localparam int AF_MSB = 7;
  localparam int AF_LSB = 4;
  localparam int AE_MSB = 3;
  localparam int AE_LSB = 0;

  typedef struct packed {
    logic [3:0] af;  // almost-full threshold
    logic [3:0] ae;  // almost-empty threshold
  } thr_t;

  localparam thr_t THR_RST = '{af: AF_RST, ae: AE_RST};

  function automatic thr_t thr_unpack(input logic [7:0] u);
    thr_t t;
    t.af = u[AF_MSB:AF_LSB];
    t.ae = u[AE_MSB:AE_LSB];
    return t;
  endfunction

endpackage

// File: rtl/fifo_vcfc_if.sv
// fifo_vcfc_if: write/read/threshold bundle between the upstream control
// logic (master) and the FIFO (slave).
//   push, data_in      : write request and its data
//   pop                : read request
//   umbrales_VCFC      : [7:4] almost-full, [3:0] almost-empty thresholds
//   data_out, valid_out: registered read data and its qualifier
//   FIFO_empty/full, almost_full/empty, FIFO_error : status back to master
interface fifo_vcfc_if #(
  parameter int DATA_W = fifo_vcfc_pkg::DATA_W_DEF
);
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [7:0]        umbrales_VCFC;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              FIFO_empty;
  logic              FIFO_full;
  logic              almost_full;
  logic              almost_empty;
  logic              FIFO_error;

  modport master (
    output push, data_in, pop, umbrales_VCFC,
    input  data_out, valid_out, FIFO_empty, FIFO_full,
           almost_full, almost_empty, FIFO_error
  );

  modport slave (
    input  push, data_in, pop, umbrales_VCFC,
    output data_out, valid_out, FIFO_empty, FIFO_full,
           almost_full, almost_empty, FIFO_error
  );
endinterface

// File: rtl/fifo_vcfc_mem.sv
// fifo_mem: DEPTH x DATA_W register file, one synchronous write port and
// one registered read port. No reset on storage or read register.
//   clk           : clock
//   we/waddr/wdata: write port
//   re/raddr      : read request; rdata updates on the edge, else holds
//   rdata         : registered read data
// A read and write to the same address on one edge returns the old word.
module fifo_mem #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_vcfc.sv
// fifo_vcfc: virtual-channel flow-control FIFO.
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : fifo_vcfc_if slave (push/pop/data/thresholds in, status out)
// Pops return data one cycle later with valid_out. Overflow (push when full
// without pop) and underflow (pop when empty) are dropped and raise the
// sticky FIFO_error. Thresholds are re-registered from umbrales_VCFC every
// cycle; flags are pure compares of registered count and thresholds.
module fifo_vcfc
  import fifo_vcfc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF   // power of two, <= 15
) (
  input  logic        clk,
  input  logic        reset,
  fifo_vcfc_if.slave  bus
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [3:0]        count;
  thr_t              thr;
  logic              err;
  logic              valid_q;
  logic              rd_seen;   // a word has been read since reset
  logic [DATA_W-1:0] rd_data;

  logic full, empty, push_ok, pop_ok, ovf, unf;

  assign full  = (count == DEPTH_C);
  assign empty = (count == 4'd0);

  // A pop on a full FIFO frees the slot, so the paired push is legal.
  assign pop_ok  = bus.pop & ~empty;
  assign push_ok = bus.push & (~full | pop_ok);
  assign ovf     = bus.push & full & ~bus.pop;
  assign unf     = bus.pop & empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= 4'd0;
      thr     <= THR_RST;
      err     <= 1'b0;
      valid_q <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      thr     <= thr_unpack(bus.umbrales_VCFC);
      err     <= err | ovf | unf;
      valid_q <= pop_ok;
      if (pop_ok) rd_seen <= 1'b1;
    end
  end

  // The read register has no reset; mask it to zero until the first pop
  // after reset so data_out clears asynchronously with everything else.
  assign bus.data_out     = rd_seen ? rd_data : '0;
  assign bus.valid_out    = valid_q;
  assign bus.FIFO_empty   = empty;
  assign bus.FIFO_full    = full;
  assign bus.almost_full  = (thr.af != 4'd0) && (count >= thr.af);
  assign bus.almost_empty = (count <= thr.ae);
  assign bus.FIFO_error   = err;

endmodule

// File: doc/fifo_vcfc.md
FIFO_VCFC -- requirements
Module: fifo_vcfc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries; the value SHALL be a power of two and no greater than 15.
REQ-003 The block SHALL have port clk, input, width 1: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port push, input, width 1: write request, carrying data_in.
REQ-006 The block SHALL have port data_in, input, width DATA_W: write data.
REQ-007 The block SHALL have port pop, input, width 1: read request.
REQ-008 The block SHALL have port umbrales_VCFC, input, width 8: thresholds from the control FSM, with [7:4] the almost-full threshold and [3:0] the almost-empty threshold.
REQ-009 The block SHALL have port data_out, output, width DATA_W: registered read data.
REQ-010 The block SHALL have port valid_out, output, width 1: data_out is valid for this cycle.
REQ-011 The block SHALL have port FIFO_empty, output, width 1: occupancy is 0.
REQ-012 The block SHALL have port FIFO_full, output, width 1: occupancy is DEPTH.
REQ-013 The block SHALL have port almost_full, output, width 1: flow-control pause toward the upstream.
REQ-014 The block SHALL have port almost_empty, output, width 1: occupancy is at or below the low threshold.
REQ-015 The block SHALL have port FIFO_error, output, width 1: sticky overflow/underflow flag, feeding the control FSM.

Function
REQ-016 The block SHALL keep write pointer, read pointer (log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and a count of 0..DEPTH in 4 bits.
REQ-017 A push with FIFO_full=0 SHALL write data_in at the write pointer, advance the pointer and increment the count.
REQ-018 A pop with FIFO_empty=0 SHALL present the read-pointer entry on data_out with valid_out=1 on the next cycle (1-cycle latency), advance the read pointer and decrement the count.
REQ-019 When no pop is accepted, valid_out SHALL be 0 next cycle and data_out SHALL hold its last value.
REQ-020 Push and pop accepted together SHALL leave the count unchanged and move both pointers.
REQ-021 When full, a simultaneous push and pop SHALL both be accepted, with no overflow.
REQ-022 Push with FIFO_full=1 and no pop (overflow) SHALL drop the data, leave the state unchanged and set FIFO_error.
REQ-023 Pop with FIFO_empty=1 (underflow) SHALL set FIFO_error, give valid_out=0 and leave the state unchanged, even with a simultaneous push; that push SHALL still be accepted, and no bypass path SHALL exist.
REQ-024 FIFO_error SHALL stay set until reset.
REQ-025 Thresholds SHALL be registered from umbrales_VCFC every cycle, so a new value takes effect one cycle after it is applied.
REQ-026 almost_full SHALL equal (count >= af_thr), and SHALL be 0 when af_thr = 0.
REQ-027 almost_empty SHALL equal (count <= ae_thr).
REQ-028 Flags SHALL be computed combinationally from the registered count and registered thresholds, with no lookahead.
REQ-029 A threshold value greater than DEPTH SHALL never assert almost_full (naturally true of the compare).

Reset
REQ-030 Asserting reset SHALL immediately clear: pointers, count, data_out=0, valid_out=0, FIFO_error=0, FIFO_full=0, almost_full=0.
REQ-031 During reset, FIFO_empty=1 and almost_empty=1.
REQ-032 Reset SHALL set the threshold registers to af_thr=6 and ae_thr=1.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset asserted mid-transfer SHALL discard all stored words, and no valid_out SHALL follow the reset release.
REQ-035 The first accepted push or pop SHALL be on the first rising edge with reset low.

Structure
REQ-036 A shared package SHALL hold DATA_W/DEPTH defaults, reset threshold constants (AF_RST=6, AE_RST=1) and the nibble field positions of umbrales_VCFC.
REQ-037 Storage SHALL be one sub-module, fifo_mem: a DEPTH x DATA_W register file with one synchronous write port and one registered read port, no reset.
REQ-038 Pointer, count, flag and error logic SHALL reside in fifo_vcfc.

Verification
REQ-039 Reset, then push 8 words 0x01..0x08 -> FIFO_full=1 after the 8th, and almost_full=1 from count 6; then pop 8 -> data_out 0x01..0x08 in order, each 1 cycle after its pop, then FIFO_empty=1.
REQ-040 Full FIFO, push 0x3F with no pop -> FIFO_error=1, count stays 8, and 0x3F is never read; FIFO_error stays 1 until reset.
REQ-041 Empty FIFO, pop together with push 0x2A -> FIFO_error=1, valid_out=0, count=1; next pop returns 0x2A.
REQ-042 Full FIFO, simultaneous push 0x15 and pop -> FIFO_error=0, count stays 8, oldest word out; 0x15 read out last.
REQ-043 umbrales_VCFC=0x32 with count=2 -> one cycle later almost_full=0 and almost_empty=1; at count=3, almost_full=1 and almost_empty=0.
REQ-044 Reset asserted asynchronously mid-cycle with count=5 -> all outputs at reset values before the next edge, and after release FIFO_empty=1 with no valid_out.
